// File: rtl/time_set_entry_pkg.sv
// Shared definitions for the keypad time/date entry controller: digit index
// map, controller states, the power-on digit vector and the calendar helpers
// used by the validator.
package time_set_pkg;

    localparam int DIGIT_W   = 4;
    localparam int N_DIGITS  = 14;
    localparam int VEC_W     = DIGIT_W * N_DIGITS;

    // Digit slot positions inside the packed 56-bit vector (slot i at [4i+3:4i]).
    localparam int IDX_10HOUR   = 0;
    localparam int IDX_HOUR     = 1;
    localparam int IDX_10MINUTE = 2;
    localparam int IDX_MINUTE   = 3;
    localparam int IDX_10SECOND = 4;
    localparam int IDX_SECOND   = 5;
    localparam int IDX_10DAY    = 6;
    localparam int IDX_DAY      = 7;
    localparam int IDX_10MONTH  = 8;
    localparam int IDX_MONTH    = 9;
    localparam int IDX_MILLENIA = 10;
    localparam int IDX_CENTURY  = 11;
    localparam int IDX_DECADE   = 12;
    localparam int IDX_YEAR     = 13;

    localparam logic [3:0] LAST_CURSOR = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    // 00:00:00 01.01.1999, slot 13 in the top nibble.
    localparam logic [VEC_W-1:0] RESET_DIGITS = 56'h99911010000000;

    function automatic logic [3:0] get_digit(input logic [VEC_W-1:0] vec, input int idx);
        return vec[idx*DIGIT_W +: DIGIT_W];
    endfunction

    // Two BCD digits to a binary value; non-BCD digits still produce a
    // number (rejected separately by the per-digit range check).
    function automatic logic [7:0] bcd2(input logic [3:0] hi, input logic [3:0] lo);
        return ({4'd0, hi} * 8'd10) + {4'd0, lo};
    endfunction

    function automatic logic [4:0] days_in_month(input logic [7:0] month, input logic leap);
        case (month)
            8'd2:                    return leap ? 5'd29 : 5'd28;
            8'd4, 8'd6, 8'd9, 8'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    function automatic logic [3:0] cursor_inc(input logic [3:0] c);
        return (c == LAST_CURSOR) ? 4'd0 : c + 4'd1;
    endfunction

    function automatic logic [3:0] cursor_dec(input logic [3:0] c);
        return (c == 4'd0) ? LAST_CURSOR : c - 4'd1;
    endfunction

endpackage

// File: rtl/time_set_entry_validator.sv
// time_set_validator: combinational plausibility check of a 14-digit BCD
// time/date value (digit ranges, 24h clock, month 1..12, day within month
// including Gregorian leap years).
// Ports: shadow (in, 56) packed digits; valid (out, 1) value acceptable.
module time_set_validator
    import time_set_pkg::*;
(
    input  logic [VEC_W-1:0] shadow,
    output logic             valid
);

    logic       w_all_bcd;
    logic [7:0] w_hour;
    logic [7:0] w_month;
    logic [7:0] w_day;
    logic [7:0] w_yy;
    logic [7:0] w_cc;
    logic       w_leap;
    logic [4:0] w_dim;

    always_comb begin
        w_all_bcd = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (get_digit(shadow, i) > 4'd9) w_all_bcd = 1'b0;
        end

        w_hour  = bcd2(get_digit(shadow, IDX_10HOUR),   get_digit(shadow, IDX_HOUR));
        w_month = bcd2(get_digit(shadow, IDX_10MONTH),  get_digit(shadow, IDX_MONTH));
        w_day   = bcd2(get_digit(shadow, IDX_10DAY),    get_digit(shadow, IDX_DAY));
        w_yy    = bcd2(get_digit(shadow, IDX_DECADE),   get_digit(shadow, IDX_YEAR));
        w_cc    = bcd2(get_digit(shadow, IDX_MILLENIA), get_digit(shadow, IDX_CENTURY));

        // Divisible by 4, except century years that are not divisible by 400
        // (yy == 0 falls back to the century number mod 4).
        w_leap = (w_yy[1:0] == 2'd0) && ((w_yy != 8'd0) || (w_cc[1:0] == 2'd0));
        w_dim  = days_in_month(w_month, w_leap);

        valid = w_all_bcd
             && (get_digit(shadow, IDX_10HOUR)   <= 4'd2)
             && (w_hour <= 8'd23)
             && (get_digit(shadow, IDX_10MINUTE) <= 4'd5)
             && (get_digit(shadow, IDX_10SECOND) <= 4'd5)
             && (w_month >= 8'd1) && (w_month <= 8'd12)
             && (w_day >= 8'd1) && (w_day <= {3'd0, w_dim});
    end

endmodule

// File: rtl/time_set_entry.sv
// time_set_entry: keypad entry of a 14-digit BCD time/date into a shadow
// register, committed to the counter chain with a one-cycle load strobe.
// Ports: CLK/RST (sync active-high); set_time_enable, b_0..b_9, up, down
// level keys; cur_digits live value; set_digits/load committed value and
// strobe; set_error reject strobe; cursor edit slot; entry_active capture.
// Build option TIME_SET_VALIDATE_EN: reject implausible values with
// set_error; when undefined every commit loads and set_error is 0.
module time_set_entry
    import time_set_pkg::*;
#(
    parameter int NUM_DIGITS = 14
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      set_time_enable,
    input  logic                      b_0,
    input  logic                      b_1,
    input  logic                      b_2,
    input  logic                      b_3,
    input  logic                      b_4,
    input  logic                      b_5,
    input  logic                      b_6,
    input  logic                      b_7,
    input  logic                      b_8,
    input  logic                      b_9,
    input  logic                      up,
    input  logic                      down,
    input  logic [4*NUM_DIGITS-1:0]   cur_digits,
    output logic [4*NUM_DIGITS-1:0]   set_digits,
    output logic                      load,
    output logic                      set_error,
    output logic [3:0]                cursor,
    output logic                      entry_active
);

    logic [9:0]              w_keys;
    logic [9:0]              r_key_q;
    logic [9:0]              r_key_prev;
    logic                    r_up_q, r_up_prev;
    logic                    r_dn_q, r_dn_prev;
    logic                    r_en_q, r_en_prev;

    logic [9:0]              w_dig_rise;
    logic                    w_up_rise, w_dn_rise;
    logic                    w_en_rise, w_en_fall;
    logic [3:0]              w_dig_cnt;
    logic [3:0]              w_dig_val;
    logic                    w_valid;

    state_t                  r_state;
    logic [3:0]              r_cursor;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_set_digits;
    logic                    r_load;
    logic                    r_entry_active;

    assign w_keys = {b_9, b_8, b_7, b_6, b_5, b_4, b_3, b_2, b_1, b_0};

    assign w_dig_rise = r_key_q & ~r_key_prev;
    assign w_up_rise  = r_up_q & ~r_up_prev;
    assign w_dn_rise  = r_dn_q & ~r_dn_prev;
    assign w_en_rise  = r_en_q & ~r_en_prev;
    assign w_en_fall  = ~r_en_q & r_en_prev;

    // Count digit edges and encode the key number; only used when exactly one.
    always_comb begin
        w_dig_cnt = 4'd0;
        w_dig_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_dig_rise[i]) begin
                w_dig_cnt = w_dig_cnt + 4'd1;
                w_dig_val = 4'(i);
            end
        end
    end

`ifdef TIME_SET_VALIDATE_EN
    logic r_set_error;

    time_set_validator u_validator (
        .shadow (r_shadow),
        .valid  (w_valid)
    );

    assign set_error = r_set_error;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_set_error <= 1'b0;
        end else begin
            r_set_error <= (r_state == ST_COMMIT) && !w_valid;
        end
    end
`else
    assign w_valid   = 1'b1;
    assign set_error = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_key_q        <= '0;
            r_key_prev     <= '0;
            r_up_q         <= 1'b0;
            r_up_prev      <= 1'b0;
            r_dn_q         <= 1'b0;
            r_dn_prev      <= 1'b0;
            // Enable history resets high so an enable still held across reset
            // cannot look like a fresh request; a new press is required.
            r_en_q         <= 1'b1;
            r_en_prev      <= 1'b1;
            r_state        <= ST_IDLE;
            r_cursor       <= 4'd0;
            r_shadow       <= RESET_DIGITS;
            r_set_digits   <= RESET_DIGITS;
            r_load         <= 1'b0;
            r_entry_active <= 1'b0;
        end else begin
            r_key_q    <= w_keys;
            r_key_prev <= r_key_q;
            r_up_q     <= up;
            r_up_prev  <= r_up_q;
            r_dn_q     <= down;
            r_dn_prev  <= r_dn_q;
            r_en_q     <= set_time_enable;
            r_en_prev  <= r_en_q;

            r_load     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_en_rise) begin
                        r_state        <= ST_CAPTURE;
                        r_shadow       <= cur_digits;
                        r_cursor       <= 4'd0;
                        r_entry_active <= 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    if (w_en_fall) begin
                        // Exit takes priority; key edges in this cycle are dropped.
                        r_state        <= ST_COMMIT;
                        r_entry_active <= 1'b0;
                    end else if (w_dig_cnt == 4'd1) begin
                        r_shadow[{r_cursor, 2'b00} +: 4] <= w_dig_val;
                        r_cursor <= cursor_inc(r_cursor);
                    end else if (w_dig_cnt == 4'd0) begin
                        // Any digit edge (even an ambiguous multi-key one)
                        // suppresses cursor moves in the same cycle.
                        if (w_up_rise && !w_dn_rise) begin
                            r_cursor <= cursor_inc(r_cursor);
                        end else if (w_dn_rise && !w_up_rise) begin
                            r_cursor <= cursor_dec(r_cursor);
                        end
                    end
                end

                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    if (w_valid) begin
                        r_set_digits <= r_shadow;
                        r_load       <= 1'b1;
                    end
                end

                default: begin
                    r_state        <= ST_IDLE;
                    r_entry_active <= 1'b0;
                end
            endcase
        end
    end

    assign set_digits   = r_set_digits;
    assign load         = r_load;
    assign cursor       = r_cursor;
    assign entry_active = r_entry_active;

endmodule

// File: tb/tb_time_set_entry.sv
module tb_time_set_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_en;
    logic [9:0]  b;
    logic        up, down;
    logic [55:0] cur_digits;
    logic [55:0] set_digits;
    logic        load, set_error, entry_active;
    logic [3:0]  cursor;

    always #5 clk = ~clk;

    time_set_entry #(.NUM_DIGITS(14)) dut (
        .CLK             (clk),
        .RST             (rst),
        .set_time_enable (set_en),
        .b_0 (b[0]), .b_1 (b[1]), .b_2 (b[2]), .b_3 (b[3]), .b_4 (b[4]),
        .b_5 (b[5]), .b_6 (b[6]), .b_7 (b[7]), .b_8 (b[8]), .b_9 (b[9]),
        .up              (up),
        .down            (down),
        .cur_digits      (cur_digits),
        .set_digits      (set_digits),
        .load            (load),
        .set_error       (set_error),
        .cursor          (cursor),
        .entry_active    (entry_active)
    );

    typedef struct packed {
        logic        is_load;
        logic [55:0] digits;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [55:0] last_committed;

    // Hand-packed vectors, slot 13 in the top nibble.
    localparam logic [55:0] RST_VEC = 56'h99911010000000; // 00:00:00 01.01.1999
    localparam logic [55:0] CUR_VEC = 56'h32026051654321; // 12:34:56 15.06.2023
    localparam logic [55:0] T2_VEC  = 56'h32026051059532; // 23:59:50 15.06.2023
    localparam logic [55:0] Y2000   = 56'h00022092000000; // 00:00:00 29.02.2000
    localparam logic [55:0] Y1900   = 56'h00912092000000; // 00:00:00 29.02.1900
    localparam logic [55:0] H24_VEC = 56'h32026051654342; // 24:34:56 15.06.2023
    localparam logic [55:0] T6_VEC  = 56'h32026051658321; // 12:38:56 15.06.2023

    task automatic check_val(input string name, input logic [55:0] act, input logic [55:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every strobe cycle pops one expected commit result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (load || set_error)) begin
                checks++;
                if (load && set_error) begin
                    errors++;
                    $display("FAIL strobe_overlap: load=%b set_error=%b expected one", load, set_error);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: load=%b set_error=%b digits=%h expected none",
                             load, set_error, set_digits);
                end else begin
                    e = sb.pop_front();
                    if (e.is_load !== load || (load && set_digits !== e.digits)) begin
                        errors++;
                        $display("FAIL commit_result: load=%b digits=%h expected load=%b digits=%h",
                                 load, set_digits, e.is_load, e.digits);
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [9:0] keys, input logic p_up, input logic p_dn);
        @(negedge clk);
        b = keys; up = p_up; down = p_dn;
        cycles(2);
        b = '0; up = 1'b0; down = 1'b0;
        cycles(2);
    endtask

    task automatic digit(input int d);
        logic [9:0] k;
        k = '0;
        k[d] = 1'b1;
        press(k, 1'b0, 1'b0);
    endtask

    task automatic enter_mode();
        @(negedge clk);
        set_en = 1'b1;
        cycles(3);
        check_val("entry_active_on", {55'd0, entry_active}, 56'd1);
        check_val("cursor_on_entry", {52'd0, cursor}, 56'd0);
    endtask

    // Drop enable and expect one strobe on the third negedge afterwards.
    task automatic exit_mode(input logic is_load, input logic [55:0] digits);
        int seen;
        exp_t e;
        e.is_load = is_load;
        e.digits  = digits;
        sb.push_back(e);
        if (is_load) last_committed = digits;
        seen = 0;
        @(negedge clk);
        set_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (seen == 0 && (load || set_error)) seen = i;
        end
        check_val("commit_latency", 56'(seen), 56'd3);
        check_val("set_digits_after", set_digits, last_committed);
    endtask

    initial begin
        rst = 1'b1; set_en = 1'b0; b = '0; up = 1'b0; down = 1'b0;
        cur_digits = CUR_VEC;
        last_committed = RST_VEC;
        cycles(3);
        rst = 1'b0;
        cycles(3);

        // Reset state
        check_val("reset_set_digits", set_digits, RST_VEC);
        check_val("reset_cursor", {52'd0, cursor}, 56'd0);
        check_val("reset_flags", {53'd0, entry_active, load, set_error}, 56'd0);

        // Time entry 23:59:50, date kept from live value
        enter_mode();
        digit(2); digit(3); digit(5); digit(9); digit(5); digit(0);
        check_val("cursor_after_six", {52'd0, cursor}, 56'd6);
        exit_mode(1'b1, T2_VEC);
        check_val("entry_active_off", {55'd0, entry_active}, 56'd0);

        // Cursor wrap both ways, then a full 14-digit leap-day entry
        enter_mode();
        press('0, 1'b0, 1'b1);
        check_val("down_wrap", {52'd0, cursor}, 56'd13);
        press('0, 1'b1, 1'b0);
        check_val("up_wrap", {52'd0, cursor}, 56'd0);
        digit(0); digit(0); digit(0); digit(0); digit(0); digit(0);
        digit(2); digit(9); digit(0); digit(2); digit(2); digit(0); digit(0); digit(0);
        check_val("cursor_full_wrap", {52'd0, cursor}, 56'd0);
        exit_mode(1'b1, Y2000);

        // 29.02.1900 is not a leap day
        enter_mode();
        digit(0); digit(0); digit(0); digit(0); digit(0); digit(0);
        digit(2); digit(9); digit(0); digit(2); digit(1); digit(9); digit(0); digit(0);
`ifdef TIME_SET_VALIDATE_EN
        exit_mode(1'b0, Y1900);
`else
        exit_mode(1'b1, Y1900);
`endif

        // Hour 24
        enter_mode();
        digit(2); digit(4);
`ifdef TIME_SET_VALIDATE_EN
        exit_mode(1'b0, H24_VEC);
`else
        exit_mode(1'b1, H24_VEC);
`endif

        // Two digit keys at once are ignored; digit beats up in the same cycle
        enter_mode();
        press(10'b0010001000, 1'b0, 1'b0);
        check_val("dual_digit_cursor", {52'd0, cursor}, 56'd0);
        press('0, 1'b1, 1'b0); press('0, 1'b1, 1'b0); press('0, 1'b1, 1'b0);
        press(10'b0100000000, 1'b1, 1'b0);
        check_val("digit_beats_up", {52'd0, cursor}, 56'd4);
        exit_mode(1'b1, T6_VEC);

        // Reset mid-entry abandons the edit; later exit gives no strobe
        enter_mode();
        digit(9); digit(9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cycles(2);
        check_val("rst_entry_active", {55'd0, entry_active}, 56'd0);
        check_val("rst_cursor", {52'd0, cursor}, 56'd0);
        check_val("rst_set_digits", set_digits, RST_VEC);
        set_en = 1'b0;
        cycles(10);
        check_val("rst_stays_idle", {55'd0, entry_active}, 56'd0);
        check_val("pending_results", 56'(sb.size()), 56'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_set_entry.md
# time_set_entry

Keypad time/date entry controller for the digital clock: the writer side of the clock's set-time interface. It turns the `b_0`..`b_9`, `up` and `down` buttons into a 14-digit BCD shadow value and validates it on exit. It then issues a one-cycle `load` with the full packed value to the digit counters. It sits between the board buttons and the clock/date/year counter chain.

## Interface
Parameters:
- `NUM_DIGITS`, 14: digit slots. Fixed by the digit index map; other values are unsupported.

Ports:
- `CLK`, in, 1: system clock.
- `RST`, in, 1: synchronous, active-high reset.
- `set_time_enable`, in, 1: level. High = entry mode requested.
- `b_0`..`b_9`, in, 1 each: digit keys, level, already debounced.
- `up`, `down`, in, 1 each: cursor move keys, level.
- `cur_digits`, in, 56: live clock digits. Digit i is at [4i+3:4i].
- `set_digits`, out, 56: committed value, same packing. Registered.
- `load`, out, 1: one-cycle strobe; `set_digits` is valid while it is high.
- `set_error`, out, 1: one-cycle strobe; the commit was rejected.
- `cursor`, out, 4: slot currently being edited, 0..13.
- `entry_active`, out, 1: high in the CAPTURE state.

Digit index map:
- 0 = 10hour, 1 = hour, 2 = 10minute, 3 = minute, 4 = 10second, 5 = second
- 6 = 10day, 7 = day, 8 = 10month, 9 = month
- 10 = millenia, 11 = century, 12 = decade, 13 = year

## Operation
Key handling:
- Every key and `set_time_enable` is registered once. Actions use rising edges: current high, previous low.

States:
- IDLE: `entry_active` = 0. A rising edge of `set_time_enable` goes to CAPTURE, copies `cur_digits` into the shadow register and sets cursor to 0.
- CAPTURE: `entry_active` = 1.
  - Rising edge on exactly one digit key b_d: shadow[cursor] = d, then cursor advances by 1 (13 wraps to 0).
  - Digit edges on two or more keys in the same cycle: all are ignored.
  - `up` edge: cursor + 1, wrapping 13 → 0.
  - `down` edge: cursor − 1, wrapping 0 → 13.
  - `up` and `down` edges together: ignored.
  - A digit edge in the same cycle as `up`/`down`: the digit wins and the move is ignored.
  - Falling edge of `set_time_enable`: go to COMMIT. Key edges in that cycle are ignored.
- COMMIT: lasts one cycle, then always returns to IDLE.
  - Shadow valid: `set_digits` ← shadow, `load` = 1.
  - Shadow invalid: `set_error` = 1 and `set_digits` is unchanged.

Validity rules (only when validation is compiled in):
- Every digit ≤ 9.
- 10hour ≤ 2; hour value ≤ 23.
- 10minute ≤ 5; 10second ≤ 5.
- Month value 1..12.
- Day value 1..days_in_month. Feb = 29 in a leap year, otherwise 28. 30-day months: 4, 6, 9, 11.
- Leap year: (decade·10 + year) mod 4 = 0 AND (decade·10 + year ≠ 0 OR (millenia·10 + century) mod 4 = 0).

Reset values:
- State IDLE, cursor 0, `entry_active` 0, `load` 0, `set_error` 0.
- `set_digits` = 00:00:00 01.01.1999, i.e. digits 0–5 = 0, 10day 0, day 1, 10month 0, month 1, millenia 1, century 9, decade 9, year 9.
- A reset during CAPTURE abandons the edit and produces no `load`.

## Timing
- Falling edge of `set_time_enable` sampled at edge k → COMMIT at edge k+1 → `load` or `set_error` high for exactly the cycle after edge k+2. Latency is 2 cycles after the registered sample.
- Digit edge sampled at edge k → shadow and cursor updated at edge k+1.
- `load` and `set_error` are never high together and never high outside the one COMMIT result cycle.
- A new `set_time_enable` rising edge in the COMMIT cycle is ignored. Entry requires a fresh rising edge.

## Configuration
- `TIME_SET_VALIDATE_EN` defined: the validity rules apply; invalid entries raise `set_error`.
- Not defined: every commit asserts `load`; `set_error` is tied to 0; the validator is not instantiated.

## Structure
- `time_set_pkg`:
  - Digit index constants (IDX_10HOUR..IDX_YEAR).
  - State enum (IDLE, CAPTURE, COMMIT).
  - The reset digit vector.
  - `days_in_month` function.
- Sub-module `time_set_validator`: combinational. Takes the 56-bit shadow and produces `valid`. It holds the leap-year and month-length logic.

## Test plan
- Reset, then idle → `set_digits` = 1999-01-01 00:00:00 encoding, cursor 0, no strobes.
- Enter mode, press 2,3,5,9,5,0, exit → `load` high for 1 cycle; digits 0..5 = 2,3,5,9,5,0; digits 6..13 equal `cur_digits`.
- Edit the date to 29.02.2000, then to 29.02.1900 → `load` for 2000; `set_error` for 1900 when validation is enabled, `load` when it is disabled.
- Hour entry 2,4 → `set_error`, `set_digits` unchanged. `down` at cursor 0 → cursor 13. `up` at 13 → 0.
- b_3 and b_7 edges in the same cycle → shadow and cursor unchanged. `up` together with b_4 → digit 4 written, cursor +1 only.
- `RST` asserted mid-CAPTURE with edits pending → IDLE. A later exit of `set_time_enable` produces no `load`.
